uart_hex_display: RTL and testbench
===================================

Name: uart_hex_display

Overview:
- Consumes the byte stream from uart_receiver (o_data / o_ready_to_read) and shows the two most recent bytes as four hex digits on the 4-digit seven-segment display.
- Time-multiplexes the digits with a refresh counter.
- Drives the active-low o_segment_enable / o_display_enable / o_dot_enable pins at counter_top, replacing the constant tie-offs.

Parameters:
- REFRESH_CYCLES, 50000: clk cycles each digit stays active; min 2.
- ACTIVITY_CYCLES, 5000000: dot-on duration after a byte (optional feature only); min 1.

Ports:
- clk  input  1  system clock (clk_gen domain)
- i_reset  input  1  asynchronous, active-high reset
- i_data  input  [0:7]  received byte; index 0 = MSB
- i_ready_to_read  input  1  level from uart_receiver; rising edge = new byte valid on i_data
- o_segment_enable  output  [0:6]  segments a..g (index 0 = a), 0 = lit
- o_display_enable  output  [0:3]  digit select (index 0 = leftmost), 0 = enabled
- o_dot_enable  output  1  decimal point, 0 = lit
- o_byte_count  output  [0:7]  bytes captured since reset, wraps 255 -> 0

Behaviour:
- Reset (async assert, sync release):
  - o_display_enable = 1111
  - o_segment_enable = 1111111
  - o_dot_enable = 1
  - o_byte_count = 0
  - history empty (valid_new = valid_old = 0)
  - scan digit = 0, refresh counter = 0
- Capture:
  - Register i_ready_to_read as rdy_q (reset 0); capture when i_ready_to_read=1 and rdy_q=0.
  - On capture: old <= new, new <= i_data, valid_old <= valid_new, valid_new <= 1, o_byte_count += 1 (mod 256).
  - A level held high captures exactly once; re-capture requires a low cycle.
- Digit mapping: digit0 = old[hi nibble], digit1 = old[lo], digit2 = new[hi], digit3 = new[lo].
- Blanking: digits 0-1 show 1111111 while valid_old=0; digits 2-3 show 1111111 while valid_new=0. o_display_enable still scans.
- Scan:
  - Refresh counter counts 0..REFRESH_CYCLES-1.
  - On terminal count: counter -> 0, digit -> digit+1 (3 wraps to 0).
  - First digit advance occurs REFRESH_CYCLES cycles after reset release.
  - o_display_enable has exactly one 0 bit, at index = digit; this holds from the first clock edge after reset release.
- Output registering:
  - o_segment_enable and o_display_enable are registered from the same current digit/history state, so they always change in the same cycle (no ghosting).
  - A byte captured at edge N appears on o_segment_enable at edge N+1 if its digit is active.
- Hex encoding, a..g, 0 = lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Simultaneous events:
  - A capture coinciding with a digit advance: the new digit shows the post-capture history one cycle later; the scan timing is unaffected.
  - Two rising edges in consecutive-but-one cycles are both captured.
- Reset mid-scan or mid-byte: all state returns to reset values immediately; a level still high when reset releases is NOT captured, because rdy_q resets to 0 and the edge is seen only if i_ready_to_read is low first. Implement as: capture also requires a first-low-seen flag, set on the first cycle i_ready_to_read=0 after reset.
- o_dot_enable stays 1 unless the optional feature is compiled in.

Optional Feature:
- Macro: UART_HEX_DISPLAY_ACTIVITY_EN
- Defined:
  - Each capture loads an activity counter with ACTIVITY_CYCLES; it decrements to 0.
  - While the counter is nonzero and digit 3 is active, o_dot_enable = 0 (registered with the segments).
  - A new capture reloads the counter.
- Undefined: no counter is instantiated; o_dot_enable is tied to 1.

Test Plan:
- Reset release, no stimulus, REFRESH_CYCLES=4 -> o_display_enable cycles 0111,1011,1101,1110,0111 every 4 clks; o_segment_enable = 1111111 throughout; o_byte_count = 0.
- Pulse i_ready_to_read with i_data=0x3A -> o_byte_count=1; digit2 shows 0000110 ("3"), digit3 shows 0001000 ("A"); digits 0-1 stay blank.
- Then send 0xF5 -> digit0 "3", digit1 "A", digit2 0111000 ("F"), digit3 0100100 ("5"); o_byte_count=2.
- Hold i_ready_to_read high 20 clks with i_data changing -> exactly one capture; send 256 bytes in total -> o_byte_count wraps to 0.
- Assert i_reset mid-scan with i_ready_to_read high, release while still high -> all outputs at reset values, no capture until i_ready_to_read goes low then high.
- With UART_HEX_DISPLAY_ACTIVITY_EN, ACTIVITY_CYCLES=10 -> o_dot_enable=0 only during digit-3 slots within 10 clks of a capture, 1 otherwise; without the macro -> o_dot_enable constant 1.

Source files
------------

// File: rtl/uart_hex_display.sv
// uart_hex_display: shows the two most recent UART bytes as four hex digits
// on a time-multiplexed, active-low 4-digit seven-segment display.
// The digit-3 activity dot is built only when UART_HEX_DISPLAY_ACTIVITY_EN
// is defined. Without it, o_dot_enable is tied high.
module uart_hex_display #(
  parameter int unsigned REFRESH_CYCLES  = 50000,
  parameter int unsigned ACTIVITY_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic [0:7] i_data,
  input  logic       i_ready_to_read,
  output logic [0:6] o_segment_enable,
  output logic [0:3] o_display_enable,
  output logic       o_dot_enable,
  output logic [0:7] o_byte_count
);

  localparam int unsigned REF_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_TOP = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low a..g pattern for one hex nibble (bit 6 = segment a)
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic             r_rdy_q;
  logic             r_low_seen;
  logic [7:0]       r_new;
  logic [7:0]       r_old;
  logic             r_valid_new;
  logic             r_valid_old;
  logic [7:0]       r_count;
  logic [REF_W-1:0] r_refresh;
  logic [1:0]       r_digit;

  logic             w_capture;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic [6:0]       w_seg;
  logic [0:3]       w_disp;

  // A byte is taken on a rising edge of the ready level, but only once a low
  // level has been seen since reset so a level held across reset is ignored.
  assign w_capture = i_ready_to_read & ~r_rdy_q & r_low_seen;

  // Edge detection state
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdy_q    <= 1'b0;
      r_low_seen <= 1'b0;
    end else begin
      r_rdy_q <= i_ready_to_read;
      if (!i_ready_to_read) begin
        r_low_seen <= 1'b1;
      end
    end
  end

  // Two-deep byte history and capture counter
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_new       <= 8'h00;
      r_old       <= 8'h00;
      r_valid_new <= 1'b0;
      r_valid_old <= 1'b0;
      r_count     <= 8'h00;
    end else if (w_capture) begin
      r_old       <= r_new;
      r_new       <= i_data;
      r_valid_old <= r_valid_new;
      r_valid_new <= 1'b1;
      r_count     <= r_count + 8'd1;
    end
  end

  // Refresh counter and active-digit scan
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_refresh <= '0;
      r_digit   <= 2'd0;
    end else if (r_refresh == REF_TOP) begin
      r_refresh <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_refresh <= r_refresh + REF_W'(1);
    end
  end

  // Select the nibble and blanking for the active digit
  always_comb begin
    w_nibble = 4'h0;
    w_blank  = 1'b1;
    w_disp   = 4'b1111;
    case (r_digit)
      2'd0: begin w_nibble = r_old[7:4]; w_blank = ~r_valid_old; end
      2'd1: begin w_nibble = r_old[3:0]; w_blank = ~r_valid_old; end
      2'd2: begin w_nibble = r_new[7:4]; w_blank = ~r_valid_new; end
      default: begin w_nibble = r_new[3:0]; w_blank = ~r_valid_new; end
    endcase
    w_disp[r_digit] = 1'b0;
    w_seg = w_blank ? SEG_BLANK : hex_to_seg(w_nibble);
  end

  // Segments and digit select registered together so they switch in lockstep
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_segment_enable <= SEG_BLANK;
      o_display_enable <= 4'b1111;
    end else begin
      o_segment_enable <= w_seg;
      o_display_enable <= w_disp;
    end
  end

  assign o_byte_count = r_count;

`ifdef UART_HEX_DISPLAY_ACTIVITY_EN
  localparam int unsigned ACT_W = $clog2(ACTIVITY_CYCLES + 1);

  logic [ACT_W-1:0] r_act;
  logic             r_dot;

  // Activity timer: reload on each capture, count down to zero
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_act <= '0;
    end else if (w_capture) begin
      r_act <= ACT_W'(ACTIVITY_CYCLES);
    end else if (r_act != '0) begin
      r_act <= r_act - ACT_W'(1);
    end
  end

  // Dot lit on digit 3 while recent activity, aligned with the segments
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_dot <= 1'b1;
    end else begin
      r_dot <= ~((r_act != '0) && (r_digit == 2'd3));
    end
  end

  assign o_dot_enable = r_dot;
`else
  // ACTIVITY_CYCLES has no load in this build
  logic w_unused_activity;
  assign w_unused_activity = ^32'(ACTIVITY_CYCLES);
  assign o_dot_enable      = 1'b1;
`endif

endmodule

// File: tb/tb_uart_hex_display.sv
// Self-checking bench for uart_hex_display with REFRESH_CYCLES=4,
// ACTIVITY_CYCLES=10. Expected outputs come from an edge-indexed model:
// active digit from elapsed edges, content from a byte history queue.
module tb_uart_hex_display;

  localparam int unsigned R = 4;
  localparam int unsigned A = 10;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [0:7] i_data = 8'h00;
  logic       i_ready_to_read = 1'b0;
  logic [0:6] o_segment_enable;
  logic [0:3] o_display_enable;
  logic       o_dot_enable;
  logic [0:7] o_byte_count;

  uart_hex_display #(
    .REFRESH_CYCLES (R),
    .ACTIVITY_CYCLES(A)
  ) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_data          (i_data),
    .i_ready_to_read (i_ready_to_read),
    .o_segment_enable(o_segment_enable),
    .o_display_enable(o_display_enable),
    .o_dot_enable    (o_dot_enable),
    .o_byte_count    (o_byte_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         k = 0;
  bit         prev_rdy = 1'b0;
  bit         low_seen = 1'b0;
  logic [7:0] hist_q[$];
  int         count = 0;
  int         last_cap = 0;
  bit         have_cap = 1'b0;
  logic [0:6] hex_tbl[16];

  task automatic check_outs(input string tag, input logic [0:6] es, input logic [0:3] ed,
                            input logic edot, input logic [0:7] ec);
    checks++;
    assert (o_segment_enable === es) else begin
      failures++;
      $error("FAIL %s seg k=%0d obs=%b exp=%b", tag, k, o_segment_enable, es);
    end
    checks++;
    assert (o_display_enable === ed) else begin
      failures++;
      $error("FAIL %s disp k=%0d obs=%b exp=%b", tag, k, o_display_enable, ed);
    end
    checks++;
    assert (o_dot_enable === edot) else begin
      failures++;
      $error("FAIL %s dot k=%0d obs=%b exp=%b", tag, k, o_dot_enable, edot);
    end
    checks++;
    assert (o_byte_count === ec) else begin
      failures++;
      $error("FAIL %s count k=%0d obs=%0d exp=%0d", tag, k, o_byte_count, ec);
    end
  endtask

  // One clock with the given inputs; called just after a negedge
  task automatic step(input string tag, input logic rdy, input logic [7:0] d);
    int         dg;
    logic [0:3] ed;
    logic [0:6] es;
    logic       edot;
    logic [7:0] b;
    bit         cap;
    i_ready_to_read = rdy;
    i_data = d;
    @(posedge clk);
    k++;
    dg = ((k - 1) / R) % 4;
    ed = 4'b1111;
    ed[dg] = 1'b0;
    es = 7'b1111111;
    if (dg < 2 && hist_q.size() == 2) begin
      b = hist_q[0];
      es = (dg == 0) ? hex_tbl[b[7:4]] : hex_tbl[b[3:0]];
    end else if (dg >= 2 && hist_q.size() >= 1) begin
      b = hist_q[hist_q.size() - 1];
      es = (dg == 2) ? hex_tbl[b[7:4]] : hex_tbl[b[3:0]];
    end
`ifdef UART_HEX_DISPLAY_ACTIVITY_EN
    edot = !(dg == 3 && have_cap && (k - 1 - last_cap) < int'(A));
`else
    edot = 1'b1;
`endif
    cap = rdy && !prev_rdy && low_seen;
    if (!rdy) low_seen = 1'b1;
    prev_rdy = rdy;
    if (cap) begin
      hist_q.push_back(d);
      if (hist_q.size() > 2) void'(hist_q.pop_front());
      count++;
      last_cap = k;
      have_cap = 1'b1;
    end
    #1;
    check_outs(tag, es, ed, edot, 8'(count));
    @(negedge clk);
  endtask

  // Asynchronous reset assertion mid-cycle, hold, release on a negedge
  task automatic do_reset(input string tag);
    #2;
    i_reset = 1'b1;
    #1;
    check_outs({tag, "_async"}, 7'b1111111, 4'b1111, 1'b1, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_outs({tag, "_held"}, 7'b1111111, 4'b1111, 1'b1, 8'd0);
    @(negedge clk);
    i_reset = 1'b0;
    k = 0;
    prev_rdy = 1'b0;
    low_seen = 1'b0;
    hist_q.delete();
    count = 0;
    have_cap = 1'b0;
  endtask

  initial begin
    hex_tbl[0]  = 7'b0000001; hex_tbl[1]  = 7'b1001111;
    hex_tbl[2]  = 7'b0010010; hex_tbl[3]  = 7'b0000110;
    hex_tbl[4]  = 7'b1001100; hex_tbl[5]  = 7'b0100100;
    hex_tbl[6]  = 7'b0100000; hex_tbl[7]  = 7'b0001111;
    hex_tbl[8]  = 7'b0000000; hex_tbl[9]  = 7'b0000100;
    hex_tbl[10] = 7'b0001000; hex_tbl[11] = 7'b1100000;
    hex_tbl[12] = 7'b0110001; hex_tbl[13] = 7'b1000010;
    hex_tbl[14] = 7'b0110000; hex_tbl[15] = 7'b0111000;

    @(negedge clk);
    do_reset("rst0");

    // Idle scan: blank segments, walking digit select
    repeat (20) step("idle", 1'b0, 8'(8'($urandom)));

    // First byte 0x3A, then 0xF5
    step("b3a", 1'b1, 8'h3A);
    repeat (16) step("show3a", 1'b0, 8'(8'($urandom)));
    step("bf5", 1'b1, 8'hF5);
    repeat (16) step("showf5", 1'b0, 8'(8'($urandom)));

    // Level held high with changing data captures once
    repeat (20) step("hold", 1'b1, 8'(8'($urandom)));
    repeat (3) step("holdlo", 1'b0, 8'(8'($urandom)));

    // Random byte stream up to 256 captures (count wraps to 0)
    while (count < 256) begin
      step("rnd", 1'b1, 8'(8'($urandom)));
      if ($urandom_range(0, 3) == 0) step("rndhi", 1'b1, 8'(8'($urandom)));
      step("rndlo", 1'b0, 8'(8'($urandom)));
      repeat ($urandom_range(0, 2)) step("rndgap", 1'b0, 8'(8'($urandom)));
    end
    repeat (8) step("wrap", 1'b0, 8'(8'($urandom)));

    // Reset mid-scan with ready held high through release
    repeat (5) step("prehi", 1'b1, 8'(8'($urandom)));
    do_reset("rst1");
    repeat (10) step("posthi", 1'b1, 8'(8'($urandom)));
    step("postlo", 1'b0, 8'h00);
    step("b5c", 1'b1, 8'h5C);
    repeat (18) step("show5c", 1'b0, 8'(8'($urandom)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
